muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide instructions, placed in the EX stage beside the single-cycle ALU. It accepts one operation at a time from the decode/EX interface and iterates a shared 33-bit add/subtract datapath for 32 cycles (shift-add multiply, restoring divide). It drives a stall to the pipeline hazard unit until the result is ready.

---
 rtl/muldiv_sequencer_if.sv | 34 +++
 rtl/muldiv_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Decode/EX <-> multiply/divide sequencer handshake.
//   master : pipeline side, drives start/funct3/a/b/flush, observes status/result
//   slave  : sequencer side
//   start  : EX holds an M-extension instruction
//   funct3 : 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   a, b   : rs1 / rs2 operands
//   flush  : branch/jump taken, abort the operation
//   busy   : operation in progress
//   stall  : hold IF/ID/EX registers
//   done   : single-cycle pulse, result valid
//   result : operation result, held until the next accepted start
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, a, b, flush,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, funct3, a, b, flush,
    output busy, stall, done, result
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer for the EX stage.
// A single 33-bit add/subtract datapath is iterated 32 times: shift-add for
// multiplies, restoring division for divides. Division by zero and signed
// overflow complete in one cycle through a fast path.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : muldiv_sequencer_if slave (start/funct3/a/b/flush in,
//         busy/stall/done/result out)
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op;
  logic            neg_a;
  logic            neg_b;
  // hi: upper product half / partial remainder
  // lo: multiplier being shifted out / dividend shifting into quotient
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opb;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v,
                                               input logic en);
    // Most-negative input wraps to itself, which is its correct unsigned magnitude.
    if (en && v < 0) return XLEN'(-v);
    return v;
  endfunction

  // Fast-path detection on the live request operands
  logic            b_zero;
  logic            ovf;
  logic            fast;
  logic [XLEN-1:0] fast_val;

  always_comb begin
    b_zero   = (bus.b == '0);
    ovf      = bus.funct3[2] & ~bus.funct3[0] & (bus.a == MIN_NEG) & (bus.b == '1);
    fast     = bus.funct3[2] & (b_zero | ovf);
    fast_val = '1;
    if (b_zero) fast_val = bus.funct3[1] ? bus.a : '1;
    else        fast_val = bus.funct3[1] ? '0 : MIN_NEG;
  end

  // Which operands are treated as signed for the latched operation
  logic a_signed;
  logic b_signed;

  always_comb begin
    a_signed = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
    b_signed = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
  end

  // Shared 33-bit adder: add for multiply, subtract (x + ~y + 1) for divide
  logic [XLEN:0] add_x;
  logic [XLEN:0] add_y;
  logic [XLEN:0] add_sum;
  logic          add_cin;

  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (op[2]) begin
      add_x   = {hi, lo[XLEN-1]};
      add_y   = ~{1'b0, opb};
      add_cin = 1'b1;
    end else begin
      add_x   = {1'b0, hi};
      add_y   = lo[0] ? {1'b0, opb} : '0;
    end
    add_sum = add_x + add_y + (XLEN+1)'(add_cin);
  end

  // Sign correction and result selection, consumed in FIX
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
    quo_fix  = (neg_a ^ neg_b) ? -lo : lo;
    rem_fix  = neg_a ? -hi : hi;
    case (op)
      3'd0:                fix_val = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    fix_val = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:          fix_val = quo_fix;
      default:             fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opb      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            if (fast) begin
              result_q <= fast_val;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              op     <= bus.funct3;
              lo     <= bus.a;
              opb    <= bus.b;
              hi     <= '0;
              busy_q <= 1'b1;
              state  <= PREP;
            end
          end
        end
        PREP: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            neg_a <= a_signed & lo[XLEN-1];
            neg_b <= b_signed & opb[XLEN-1];
            lo    <= abs_val(lo, a_signed);
            opb   <= abs_val(opb, b_signed);
            hi    <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            if (op[2]) begin
              // add_sum[XLEN] set means the trial subtract borrowed: restore
              hi <= add_sum[XLEN] ? add_x[XLEN-1:0] : add_sum[XLEN-1:0];
              lo <= {lo[XLEN-2:0], ~add_sum[XLEN]};
            end else begin
              hi <= add_sum[XLEN:1];
              lo <= {add_sum[0], lo[XLEN-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            result_q <= fix_val;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.stall  = (bus.start & (state == IDLE) & ~fast) | busy_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  muldiv_sequencer_if #(.XLEN(32)) bus ();

  muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x,
                                        input logic [31:0] y);
    longint          sx, sy, sp;
    longint unsigned ux, uy, up;
    logic            ovf_case;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    ovf_case = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin up = ux * uy; return up[31:0]; end
      3'd1: begin sp = sx * sy; return sp[63:32]; end
      3'd2: begin sp = sx * longint'(uy); return sp[63:32]; end
      3'd3: begin up = ux * uy; return up[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf_case) return 32'h8000_0000;
        sp = sx / sy; return sp[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        up = ux / uy; return up[31:0];
      end
      3'd6: begin
        if (y == 0) return x;
        if (ovf_case) return 32'd0;
        sp = sx % sy; return sp[31:0];
      end
      default: begin
        if (y == 0) return x;
        up = ux % uy; return up[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] x,
                                 input logic [31:0] y);
    if (f3 < 3'd4) return 1'b0;
    if (y == 0) return 1'b1;
    return (f3 == 3'd4 || f3 == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a falling edge; returns just after a falling edge in IDLE.
  // hold=1 keeps start asserted with scrambled operands while busy, as a
  // stalled pipeline might, to show those requests are ignored.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_res, input bit hold);
    int lat, busy_n, stall_n;
    bit seen, fast;
    fast = is_fast(f3, av, bv);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = av;
    bus.b      = bv;
    #1;
    chk("stall_start", 32'(bus.stall), fast ? 32'd0 : 32'd1);
    lat = 0; busy_n = 0; stall_n = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy)  busy_n++;
        if (bus.stall) stall_n++;
        if (hold) begin
          bus.funct3 = 3'($urandom);
          bus.a      = $urandom;
          bus.b      = $urandom;
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), fast ? 32'd1 : 32'd35);
    if (!fast) begin
      chk("busy_cycles", 32'(busy_n), 32'd34);
      chk("stall_cycles", 32'(stall_n), 32'd34);
    end
    chk("result", bus.result, exp_res);
    chk("stall_done", 32'(bus.stall), 32'd0);
    chk("busy_done", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("result_hold", bus.result, exp_res);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] av, bv;
    total = 0;
    bad   = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.funct3 = 3'd0;
    bus.a      = '0;
    bus.b      = '0;
    bus.flush  = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases with hand-derived expectations
    do_op(3'd0, 32'd7,          32'd6,          32'd42,          1'b0);
    do_op(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,           1'b0);
    do_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,   1'b0);
    do_op(3'd2, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,   1'b0);
    do_op(3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,   1'b0);
    do_op(3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   1'b0);
    do_op(3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,   1'b0);
    do_op(3'd5, 32'd100,        32'd7,          32'd14,          1'b0);
    do_op(3'd7, 32'd100,        32'd7,          32'd2,           1'b0);
    do_op(3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF,   1'b0);
    do_op(3'd6, 32'd5,          32'd0,          32'd5,           1'b0);
    do_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   1'b0);
    do_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,           1'b0);
    // start held high during busy must not disturb the in-flight operation
    do_op(3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   1'b1);

    // Flush at CALC counter 10: start edge, PREP, then 11 CALC cycles
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.a = 32'd123; bus.b = 32'd456;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    chk("flush_busy_before", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy_after", 32'(bus.busy), 32'd0);
    chk("flush_no_done", 32'(bus.done), 32'd0);
    chk("flush_result_kept", bus.result, 32'hFFFF_FFFD);
    do_op(3'd0, 32'd123, 32'd456, 32'd56088, 1'b0);

    // Asynchronous reset in the middle of CALC
    bus.start = 1'b1; bus.funct3 = 3'd3; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_stall", 32'(bus.stall), 32'd0);
    chk("arst_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", 32'(bus.done), 32'd0);
    do_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678), 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      av = pick();
      bv = pick();
      do_op(f3, av, bv, model(f3, av, bv), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
